// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response and decode handoff.
// The master side is the fetch unit, the slave side is imem plus decode.
interface pc_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;

    // valid/ready: a request transfers on a cycle where valid and ready are both 1;
    // valid, once raised, is held with a stable address until that cycle.
    // The response and the redirect are valid-only (no backpressure).
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst_data, inst_pc, pc_plus4,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst_data, inst_pc, pc_plus4,
        output inst_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with redirect/flush.
// dbg_state_o exposes the FSM state: 0=BOOT 1=REQ 2=WAIT 3=HOLD.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    output logic                   misalign_fault,
    output logic [1:0]             dbg_state_o,
    pc_fetch_unit_if.master        bus
);
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_HOLD = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] ipc_q, ipc_d;
    logic        fault_q, fault_d;

    logic        redir_ok;
    logic        redir_bad;

    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
            idata_q <= 32'h0;
            ipc_q   <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            idata_q <= idata_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
        end
    end

    // addr_q is only reloaded on entry to REQ, so a pending request keeps its
    // address even when a redirect moves pc underneath it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        idata_d = idata_q;
        ipc_d   = ipc_q;
        fault_d = redir_bad;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                addr_d  = pc_q;
            end
            ST_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
                if (redir_ok) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (redir_ok) begin
                        pc_d    = redirect_target;
                        addr_d  = redirect_target;
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (drop_q) begin
                        addr_d  = pc_q;
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        idata_d = bus.imem_resp_data;
                        ipc_d   = pc_q;
                        state_d = ST_HOLD;
                    end
                end else if (redir_ok) begin
                    pc_d   = redirect_target;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Redirect outranks consumption: the target replaces pc+4.
                if (redir_ok) begin
                    pc_d    = redirect_target;
                    addr_d  = redirect_target;
                    state_d = ST_REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    addr_d  = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = addr_q;
    assign bus.inst_valid     = (state_q == ST_HOLD);
    assign bus.inst_data      = idata_q;
    assign bus.inst_pc        = ipc_q;
    assign bus.pc_plus4       = ipc_q + 32'd4;
    assign misalign_fault     = fault_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot sequence, backpressure, redirects,
// misaligned target, PC wrap and asynchronous reset during a fetch.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        misalign_fault;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_fault  (misalign_fault),
        .dbg_state_o     (dbg_state),
        .bus             (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // imem contents used by this bench: word at address a is a ^ 32'h5A5A_0F0F
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver: from REQ, accept the request, return the word, land in HOLD
    task automatic fetch_to_hold();
        logic [31:0] a;
        a = exp_q.pop_front();
        check("req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("req_addr", bus.imem_req_addr, a);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check("wait_no_inst", {31'h0, bus.inst_valid}, 32'h0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word_at(a);
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        check("hold_valid", {31'h0, bus.inst_valid}, 32'h1);
        check("hold_pc", bus.inst_pc, a);
        check("hold_data", bus.inst_data, word_at(a));
        check("hold_plus4", bus.pc_plus4, a + 32'd4);
        check("hold_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
    endtask

    task automatic consume();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("consumed", {31'h0, bus.inst_valid}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
        check({tag, "_req_valid"}, {31'h0, bus.imem_req_valid}, 32'h0);
        check({tag, "_req_addr"}, bus.imem_req_addr, RST_PC);
        check({tag, "_inst_valid"}, {31'h0, bus.inst_valid}, 32'h0);
        check({tag, "_inst_data"}, bus.inst_data, 32'h0);
        check({tag, "_inst_pc"}, bus.inst_pc, RST_PC);
        check({tag, "_fault"}, {31'h0, misalign_fault}, 32'h0);
    endtask

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready      = 1'b0;

        // 1: reset, boot cycle, three sequential fetches
        repeat (2) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        check("boot_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        check("boot_to_req", {30'h0, dbg_state}, 32'h1);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h0000_0108);
        for (int i = 0; i < 3; i++) begin
            fetch_to_hold();
            consume();
        end

        // 2: request backpressure, then decode backpressure
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
            check("bp_req_addr", bus.imem_req_addr, 32'h0000_010C);
            tick();
        end
        exp_q.push_back(32'h0000_010C);
        fetch_to_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_inst_valid", {31'h0, bus.inst_valid}, 32'h1);
            check("bp_inst_pc", bus.inst_pc, 32'h0000_010C);
            check("bp_inst_data", bus.inst_data, word_at(32'h0000_010C));
            check("bp_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        end
        consume();

        // 3: redirect while a request is pending, then redirect in HOLD with inst_ready
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        redirect_valid  = 1'b0;
        check("pend_addr_stable", bus.imem_req_addr, 32'h0000_0110);
        check("pend_valid_stable", {31'h0, bus.imem_req_valid}, 32'h1);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word_at(32'h0000_0110);
        tick();
        bus.imem_resp_valid = 1'b0;
        check("stale_dropped", {31'h0, bus.inst_valid}, 32'h0);
        exp_q.push_back(32'h0000_0200);
        fetch_to_hold();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        bus.inst_ready  = 1'b1;
        tick();
        redirect_valid  = 1'b0;
        bus.inst_ready  = 1'b0;
        check("hold_redir_inval", {31'h0, bus.inst_valid}, 32'h0);
        check("hold_redir_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("hold_redir_addr", bus.imem_req_addr, 32'h0000_0040);

        // 4: redirect in WAIT, response later; then response in the same cycle
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0080;
        tick();
        redirect_valid  = 1'b0;
        check("wait_redir_state", {30'h0, dbg_state}, 32'h2);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("wait_redir_inval", {31'h0, bus.inst_valid}, 32'h0);
        check("wait_redir_addr", bus.imem_req_addr, 32'h0000_0080);
        tick();
        check("wait_redir_inval2", {31'h0, bus.inst_valid}, 32'h0);
        check("wait_redir_data_kept", bus.inst_data, word_at(32'h0000_0200));
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_00C0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        check("same_cyc_inval", {31'h0, bus.inst_valid}, 32'h0);
        check("same_cyc_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("same_cyc_addr", bus.imem_req_addr, 32'h0000_00C0);

        // 5: misaligned redirect is ignored with a one-cycle fault; then PC wrap
        exp_q.push_back(32'h0000_00C0);
        fetch_to_hold();
        check("fault_idle", {31'h0, misalign_fault}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0102;
        tick();
        redirect_valid  = 1'b0;
        check("fault_pulse", {31'h0, misalign_fault}, 32'h1);
        check("fault_hold_valid", {31'h0, bus.inst_valid}, 32'h1);
        check("fault_hold_pc", bus.inst_pc, 32'h0000_00C0);
        tick();
        check("fault_cleared", {31'h0, misalign_fault}, 32'h0);
        consume();
        check("fault_next_addr", bus.imem_req_addr, 32'h0000_00C4);
        exp_q.push_back(32'h0000_00C4);
        fetch_to_hold();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid  = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        fetch_to_hold();
        check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
        consume();
        check("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // 6: async reset in WAIT with a response pulsing through and after reset
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check("pre_rst_wait", {30'h0, dbg_state}, 32'h2);
        rst_n = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word_at(32'h0000_0000);
        #1;
        check_reset_outputs("arst");
        tick();
        check("arst_no_inst", {31'h0, bus.inst_valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("arst_late_resp_ignored", {31'h0, bus.inst_valid}, 32'h0);
        check("arst_restart_state", {30'h0, dbg_state}, 32'h1);
        exp_q.push_back(RST_PC);
        fetch_to_hold();
        consume();
        check("exp_q_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
